// File: rtl/joy_db15_if.sv
// DB15 serial joystick link: the initiator drives the shift clock and the load strobe,
// and the responder returns the serial button data.
interface joy_db15_if;
    logic joy_clk_in;
    logic joy_load_in;
    logic joy_data_out;

    modport master (
        output joy_clk_in,
        output joy_load_in,
        input  joy_data_out
    );

    modport slave (
        input  joy_clk_in,
        input  joy_load_in,
        output joy_data_out
    );
endinterface

// File: rtl/joy_db15_responder.sv
// Responder end of the DB15 joystick link: a 74HC165-style parallel-in/serial-out chain
// holding both players' button words, with frame-completion and link-liveness reporting.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | out of reset, no load seen yet; chain holds all 1s
// LOADED | load seen (or still low), waiting for the first shift edge
// SHIFT  | shifting a frame, bit_cnt = shifts done so far
// DONE   | full frame shifted out, further edges only shift in 1s
module joy_db15_responder #(
    parameter int CHAIN_BITS     = 24,
    parameter int TIMEOUT_CYCLES = 4800000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] joystick1,
    input  logic [11:0] joystick2,
    joy_db15_if.slave   link,
    output logic        frame_done,
    output logic        link_ok
);
    localparam int CW = $clog2(CHAIN_BITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CHAIN_BITS);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] ld_sync_q;
    logic                   clk_prev_q;
    logic                   ld_prev_q;
    logic                   clk_s;
    logic                   ld_s;
    logic                   rise;
    logic                   ld_fall;

    logic [CHAIN_BITS-1:0]  sr_q;
    logic [CHAIN_BITS-1:0]  sr_d;
    logic [CHAIN_BITS-1:0]  load_val;
    logic                   data_q;

    logic [TW-1:0]          timeout_q;
    logic [TW-1:0]          timeout_d;
    logic                   link_ok_q;
    logic                   link_ok_d;

    state_t                 state_q;
    logic [CW-1:0]          bit_cnt_q;
    logic [CW-1:0]          bit_cnt_inc;
    logic                   frame_done_q;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign ld_s    = ld_sync_q[SYNC_STAGES-1];
    assign rise    = clk_s & ~clk_prev_q;
    assign ld_fall = ~ld_s & ld_prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync_q <= '1;
            ld_sync_q  <= '1;
            clk_prev_q <= 1'b1;
            ld_prev_q  <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], link.joy_clk_in};
            ld_sync_q  <= {ld_sync_q[SYNC_STAGES-2:0], link.joy_load_in};
            clk_prev_q <= clk_s;
            ld_prev_q  <= ld_s;
        end
    end

    // Load is level-sensitive and overrides any coincident shift edge.
    always_comb begin
        load_val       = '1;
        load_val[23:0] = ~{joystick2, joystick1};
        sr_d           = sr_q;
        if (!ld_s) begin
            sr_d = load_val;
        end else if (rise) begin
            sr_d = {1'b1, sr_q[CHAIN_BITS-1:1]};
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if (ld_fall) begin
            timeout_d = '0;
        end else if (timeout_q != TO_MAX) begin
            timeout_d = timeout_q + 1'b1;
        end
        link_ok_d = ld_fall | (link_ok_q & (timeout_d != TO_MAX));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_q      <= '1;
            data_q    <= 1'b1;
            timeout_q <= '0;
            link_ok_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            data_q    <= sr_q[0];
            timeout_q <= timeout_d;
            link_ok_q <= link_ok_d;
        end
    end

    assign bit_cnt_inc = bit_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!ld_s) begin
                state_q   <= LOADED;
                bit_cnt_q <= '0;
            end else if (rise) begin
                case (state_q)
                    LOADED, SHIFT: begin
                        bit_cnt_q <= bit_cnt_inc;
                        if (bit_cnt_inc == CNT_FULL) begin
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                    IDLE, DONE: begin
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign link.joy_data_out = data_q;
    assign frame_done        = frame_done_q;
    assign link_ok           = link_ok_q;
endmodule
